// File: rtl/gate_seq_pkg.sv
// Shared types and sizing helpers for the gate test sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    // Settle counter width: max($clog2(SETTLE_CYCLES), 1).
    function automatic int cnt_width(input int settle_cycles);
        int w;
        w = $clog2(settle_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Loadable settle down-counter; holds at zero and flags it.
module gate_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks every input vector of a gate under test and checks its output against a latched truth table.
// Optional first-failure capture is built when GATE_SEQ_FAIL_CAPTURE_EN is defined.
//
// state  | meaning
// IDLE   | waiting for START
// SETTLE | driving vec, counting down the settle time
// SAMPLE | comparing DUT_O with the expected bit for vec
// FINISH | one-cycle DONE, result published
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [2**N_IN-1:0]    TRUTH,
    input  logic                  DUT_O,
    output logic [N_IN-1:0]       DUT_I,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [N_IN:0]         ERR_CNT,
    output logic                  FAIL_VALID,
    output logic [N_IN-1:0]       FAIL_VEC,
    output logic                  FAIL_OBS
);

    localparam int NVEC = vec_count(N_IN);
    localparam int CW   = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    seq_state_t        state, state_next;
    logic [NVEC-1:0]   truth_q;
    logic [N_IN-1:0]   vec;
    logic [N_IN:0]     err_cnt;
    logic              pass_q;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;
    logic              start_acc;
    logic              last_vec;
    logic              mismatch;
    logic              timer_load;
    logic              timer_en;

    assign start_acc  = (state == ST_IDLE) && START;
    assign last_vec   = (vec == {N_IN{1'b1}});
    assign mismatch   = (state == ST_SAMPLE) && (DUT_O != truth_q[vec]);
    assign timer_load = start_acc || ((state == ST_SAMPLE) && !last_vec);
    assign timer_en   = (state == ST_SETTLE);

    gate_seq_timer #(.W(CW)) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (timer_load),
        .load_val (CNT_LOAD),
        .en       (timer_en),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (START) state_next = ST_SETTLE;
            ST_SETTLE: if (cnt_zero) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = last_vec ? ST_FINISH : ST_SETTLE;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            ST_SETTLE, ST_SAMPLE: BUSY = 1'b1;
            ST_FINISH:            DONE = 1'b1;
            default:              ;
        endcase
    end

    // PASS is resolved on the edge into FINISH so it is already valid while DONE is high.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            truth_q <= '0;
            vec     <= '0;
            err_cnt <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        truth_q <= TRUTH;
                        vec     <= '0;
                        err_cnt <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) err_cnt <= err_cnt + (N_IN+1)'(1);
                    if (last_vec) pass_q <= (err_cnt == '0) && !mismatch;
                    else          vec    <= vec + N_IN'(1);
                end
                ST_FINISH: vec <= '0;
                default: ;
            endcase
        end
    end

    assign DUT_I   = vec;
    assign PASS    = pass_q;
    assign ERR_CNT = err_cnt;

`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic            fail_valid_q;
    logic [N_IN-1:0] fail_vec_q;
    logic            fail_obs_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_obs_q   <= 1'b0;
        end else if (start_acc) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_obs_q   <= 1'b0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec;
            fail_obs_q   <= DUT_O;
        end
    end

    assign FAIL_VALID = fail_valid_q;
    assign FAIL_VEC   = fail_vec_q;
    assign FAIL_OBS   = fail_obs_q;
`else
    assign FAIL_VALID = 1'b0;
    assign FAIL_VEC   = '0;
    assign FAIL_OBS   = 1'b0;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: a NOT instance (N_IN=1) and an AND instance (N_IN=2), both SETTLE_CYCLES=4.
module tb_gate_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic rst_n;

`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // NOT gate under test, optionally stuck at 1
    logic       start1, stuck1, o1, busy1, done1, pass1, fv1, fobs1;
    logic [1:0] truth1, err1;
    logic [0:0] i1, fvec1;
    assign o1 = stuck1 ? 1'b1 : ~i1[0];

    // AND gate under test
    logic       start2, o2, busy2, done2, pass2, fv2, fobs2;
    logic [3:0] truth2;
    logic [1:0] i2, fvec2;
    logic [2:0] err2;
    assign o2 = &i2;

    gate_test_sequencer #(.N_IN(1), .SETTLE_CYCLES(4)) u_not (
        .CLK(clk), .RST_N(rst_n), .START(start1), .TRUTH(truth1), .DUT_O(o1),
        .DUT_I(i1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
        .FAIL_VALID(fv1), .FAIL_VEC(fvec1), .FAIL_OBS(fobs1)
    );

    gate_test_sequencer #(.N_IN(2), .SETTLE_CYCLES(4)) u_and (
        .CLK(clk), .RST_N(rst_n), .START(start2), .TRUTH(truth2), .DUT_O(o2),
        .DUT_I(i2), .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2),
        .FAIL_VALID(fv2), .FAIL_VEC(fvec2), .FAIL_OBS(fobs2)
    );

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; stuck1 = 1'b0;
        truth1 = '0; truth2 = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy1, done1, pass1, err1, i1, fv1, fvec1, fobs1} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_not outputs got %b exp 0", {busy1, done1, pass1, err1, i1, fv1, fvec1, fobs1});
        end
        tests_run++;
        if ({busy2, done2, pass2, err2, i2, fv2, fvec2, fobs2} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_and outputs got %b exp 0", {busy2, done2, pass2, err2, i2, fv2, fvec2, fobs2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_not_gate(input logic stuck);
        logic [0:0] ev;
        logic       exp_cap;
        exp_cap = CAP && stuck;
        stuck1 = stuck; truth1 = 2'b01;
        start1 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            tests_run++;
            if (busy1 !== (c <= 10)) begin
                tests_failed++;
                $display("FAIL not_busy c=%0d got %b exp %b", c, busy1, (c <= 10));
            end
            tests_run++;
            if (done1 !== (c == 11)) begin
                tests_failed++;
                $display("FAIL not_done c=%0d got %b exp %b", c, done1, (c == 11));
            end
            if (c != 11) begin
                ev = (c >= 6 && c <= 10) ? 1'b1 : 1'b0;
                tests_run++;
                if (i1 !== ev) begin
                    tests_failed++;
                    $display("FAIL not_dut_i c=%0d got %b exp %b", c, i1, ev);
                end
            end
            if (c == 1) begin
                tests_run++;
                if ({pass1, err1, fv1} !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL not_clear_on_start got %b exp 0000", {pass1, err1, fv1});
                end
            end
            if (c == 11 || c == 14) begin
                tests_run++;
                if (err1 !== {1'b0, stuck}) begin
                    tests_failed++;
                    $display("FAIL not_err_cnt c=%0d got %0d exp %0d", c, err1, stuck);
                end
                tests_run++;
                if (pass1 !== !stuck) begin
                    tests_failed++;
                    $display("FAIL not_pass c=%0d got %b exp %b", c, pass1, !stuck);
                end
                tests_run++;
                if ({fv1, fvec1, fobs1} !== {3{exp_cap}}) begin
                    tests_failed++;
                    $display("FAIL not_fail_capture c=%0d got %b exp %b", c, {fv1, fvec1, fobs1}, {3{exp_cap}});
                end
            end
        end
    endtask

    task automatic test_and_gate(input logic [3:0] truth, input logic [2:0] exp_err,
                                 input logic [1:0] exp_fvec, input logic exp_fobs);
        logic [1:0] ev;
        logic [3:0] exp_cap;
        exp_cap = (CAP && exp_err != 0) ? {1'b1, exp_fvec, exp_fobs} : 4'd0;
        truth2 = truth;
        start2 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            if (c == 3) truth2 = ~truth;
            tests_run++;
            if (busy2 !== (c <= 20)) begin
                tests_failed++;
                $display("FAIL and_busy c=%0d got %b exp %b", c, busy2, (c <= 20));
            end
            tests_run++;
            if (done2 !== (c == 21)) begin
                tests_failed++;
                $display("FAIL and_done c=%0d got %b exp %b", c, done2, (c == 21));
            end
            if (c != 21) begin
                ev = (c <= 20) ? 2'((c - 1) / 5) : 2'd0;
                tests_run++;
                if (i2 !== ev) begin
                    tests_failed++;
                    $display("FAIL and_dut_i c=%0d got %0d exp %0d", c, i2, ev);
                end
            end
            if (c == 1) begin
                tests_run++;
                if ({pass2, err2, fv2} !== 5'd0) begin
                    tests_failed++;
                    $display("FAIL and_clear_on_start got %b exp 00000", {pass2, err2, fv2});
                end
            end
            if (c == 21) begin
                tests_run++;
                if (err2 !== exp_err) begin
                    tests_failed++;
                    $display("FAIL and_err_cnt got %0d exp %0d", err2, exp_err);
                end
                tests_run++;
                if (pass2 !== (exp_err == 0)) begin
                    tests_failed++;
                    $display("FAIL and_pass got %b exp %b", pass2, (exp_err == 0));
                end
                tests_run++;
                if ({fv2, fvec2, fobs2} !== exp_cap) begin
                    tests_failed++;
                    $display("FAIL and_fail_capture got %b exp %b", {fv2, fvec2, fobs2}, exp_cap);
                end
            end
        end
        truth2 = truth;
    endtask

    task automatic test_start_ignored();
        logic [1:0] ev;
        int done_cnt = 0;
        truth2 = 4'b1000;
        start2 = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (done2) done_cnt++;
            tests_run++;
            if (busy2 !== (c <= 20)) begin
                tests_failed++;
                $display("FAIL repulse_busy c=%0d got %b exp %b", c, busy2, (c <= 20));
            end
            if (c != 21) begin
                ev = (c <= 20) ? 2'((c - 1) / 5) : 2'd0;
                tests_run++;
                if (i2 !== ev) begin
                    tests_failed++;
                    $display("FAIL repulse_dut_i c=%0d got %0d exp %0d", c, i2, ev);
                end
            end
            if (c == 21) begin
                tests_run++;
                if (pass2 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL repulse_pass got %b exp 1", pass2);
                end
            end
            start2 = (c == 7 || c == 21) ? 1'b1 : 1'b0;
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL repulse_done_count got %0d exp 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_cnt = 0;
        truth2 = 4'b1001;
        start2 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
        end
        tests_run++;
        if ({busy2, err2} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL midrun_before_reset busy,err got %b exp 1001", {busy2, err2});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if ({busy2, i2, err2, done2, pass2} !== 8'd0) begin
            tests_failed++;
            $display("FAIL midrun_after_reset got %b exp 0", {busy2, i2, err2, done2, pass2});
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done2 || busy2) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL midrun_activity_after_reset got %0d cycles exp 0", done_cnt);
        end
        truth2 = 4'b1000;
        start2 = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            if (done2) begin
                done_cnt++;
                tests_run++;
                if (c !== 21) begin
                    tests_failed++;
                    $display("FAIL rerun_done_cycle got %0d exp 21", c);
                end
                tests_run++;
                if ({pass2, err2} !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL rerun_result pass,err got %b exp 1000", {pass2, err2});
                end
            end
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL rerun_done_count got %0d exp 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_not_gate(1'b1);
        test_not_gate(1'b0);
        test_and_gate(4'b1110, 3'd2, 2'd1, 1'b0);
        test_and_gate(4'b1000, 3'd0, 2'd0, 1'b0);
        test_start_ignored();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
